// File: rtl/mini_src_pkg.sv
// Shared ALU select codes, multiply/divide iteration count and helpers.
package mini_src_pkg;

   localparam logic [4:0] ALU_ADD = 5'b00011;
   localparam logic [4:0] ALU_SUB = 5'b00100;
   localparam logic [4:0] ALU_AND = 5'b00101;
   localparam logic [4:0] ALU_OR  = 5'b00110;
   localparam logic [4:0] ALU_SHR = 5'b00111;
   localparam logic [4:0] ALU_SHL = 5'b01000;
   localparam logic [4:0] ALU_MUL = 5'b01001;
   localparam logic [4:0] ALU_DIV = 5'b01010;
   localparam logic [4:0] ALU_NEG = 5'b01011;
   localparam logic [4:0] ALU_NOT = 5'b01100;

   localparam int unsigned MULDIV_ITER = 32;
   localparam int unsigned CNT_W       = $clog2(MULDIV_ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } muldiv_state_e;

   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/addsub33.sv
// 33-bit ripple-carry adder/subtractor shared by the Booth and division paths.
module addsub33 (
   input  logic [32:0] a,
   input  logic [32:0] b,
   input  logic        sub,
   output logic [32:0] sum,
   output logic        cout
);

   logic [32:0] b_eff;
   logic [33:0] carry;

   always_comb begin
      b_eff    = b ^ {33{sub}};
      carry    = '0;
      sum      = '0;
      carry[0] = sub;
      for (int i = 0; i < 33; i++) begin
         sum[i]       = a[i] ^ b_eff[i] ^ carry[i];
         carry[i + 1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
      end
      cout = carry[33];
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (non-restoring) unit.
// Fixed 34-cycle latency from acceptance to the done pulse.
module muldiv_unit
   import mini_src_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [4:0]  select,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [63:0] Zwide,
   output logic        div_by_zero
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_ITER - 1);

   muldiv_state_e    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [32:0]      acc_q, acc_d;
   logic [31:0]      quo_q, quo_d;
   logic             qm1_q, qm1_d;
   logic [63:0]      zwide_q, zwide_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic        accept;
   logic [31:0] div_mag;
   logic [32:0] add_a, add_b, add_sum;
   logic        add_sub;
   logic        unused_cout;
   logic [31:0] rem_mag, rem_fix, quo_fix;

   addsub33 u_addsub33 (
      .a    (add_a),
      .b    (add_b),
      .sub  (add_sub),
      .sum  (add_sum),
      .cout (unused_cout)
   );

   // Adder operand steering: Booth step, non-restoring step, or final remainder fix.
   always_comb begin
      accept  = start && (state_q == IDLE || state_q == DONE) &&
                (select == ALU_MUL || select == ALU_DIV);
      div_mag = abs32(b_q);
      add_a   = acc_q;
      add_b   = '0;
      add_sub = 1'b0;
      if (state_q == RUN) begin
         if (is_div_q) begin
            add_a   = {acc_q[31:0], quo_q[31]};
            add_b   = {1'b0, div_mag};
            add_sub = ~acc_q[32];
         end else begin
            unique case ({quo_q[0], qm1_q})
               2'b01: add_b = {a_q[31], a_q};
               2'b10: begin
                  add_b   = {a_q[31], a_q};
                  add_sub = 1'b1;
               end
               default: add_b = '0;
            endcase
         end
      end else if (state_q == FIX && acc_q[32]) begin
         add_b = {1'b0, div_mag};
      end
   end

   always_comb begin
      rem_mag = add_sum[31:0];
      quo_fix = (a_q[31] ^ b_q[31]) ? (~quo_q + 32'd1) : quo_q;
      rem_fix = a_q[31] ? (~rem_mag + 32'd1) : rem_mag;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      quo_d    = quo_q;
      qm1_d    = qm1_q;
      zwide_d  = zwide_q;
      dbz_d    = dbz_q;

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               state_d  = RUN;
               cnt_d    = '0;
               is_div_d = (select == ALU_DIV);
               a_d      = A;
               b_d      = B;
               acc_d    = '0;
               quo_d    = (select == ALU_DIV) ? abs32(A) : B;
               qm1_d    = 1'b0;
               dbz_d    = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (is_div_q) begin
               acc_d = add_sum;
               quo_d = {quo_q[30:0], ~add_sum[32]};
            end else begin
               // Arithmetic shift right of {acc, quo, q-1} after the Booth add.
               acc_d = {add_sum[32], add_sum[32:1]};
               quo_d = {add_sum[0], quo_q[31:1]};
               qm1_d = quo_q[0];
            end
            if (cnt_q == CNT_LAST) begin
               state_d = FIX;
            end
         end
         FIX: begin
            state_d = DONE;
            if (!is_div_q) begin
               zwide_d = {acc_q[31:0], quo_q};
            end else if (b_q == 32'd0) begin
               zwide_d = {a_q, 32'hFFFF_FFFF};
               dbz_d   = 1'b1;
            end else begin
               zwide_d = {rem_fix, quo_fix};
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN) || (state_d == FIX);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         quo_q    <= '0;
         qm1_q    <= 1'b0;
         zwide_q  <= '0;
         dbz_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         quo_q    <= quo_d;
         qm1_q    <= qm1_d;
         zwide_q  <= zwide_d;
         dbz_q    <= dbz_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign Zwide       = zwide_q;
   assign div_by_zero = dbz_q;

endmodule
